// File: rtl/pdatapath_mc.sv
// pdatapath_mc: multi-cycle 4-register datapath (FETCH/DECODE/EXEC/WB) with run/step control
//   clk, rst_general : clock, synchronous active-high reset
//   run, step        : free-run enable, single-instruction start pulse (sampled in IDLE)
//   imem_addr/data   : registered ROM address, ROM data valid one cycle later
//   dbg_addr/data    : combinational register-file read port
//   pc, alu_result, ovf, halted, instr_done : architectural status
module pdatapath_mc #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_general,
    input  logic              run,
    input  logic              step,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] alu_result,
    output logic              ovf,
    output logic              halted,
    output logic              instr_done
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALTED} state_t;
    state_t state, state_n;
    logic [15:0] ir;
    logic [DATA_W-1:0] rf [4];
    logic taken;
    logic [3:0] op;
    logic [1:0] rs, rt, rd, wr_sel;
    logic [DATA_W-1:0] a, b, b_op, imm_x, sum, diff, res;
    logic ovf_add, ovf_sub, wr_en;
    logic [PC_W-1:0] pc_n;

    assign op = ir[15:12];
    assign rs = ir[11:10];
    assign rt = ir[9:8];
    assign rd = ir[7:6];
    assign imm_x = DATA_W'($signed(ir[7:0]));
    // R0 is never written, so a plain array read already returns 0 for it
    assign a = rf[rs];
    assign b = rf[rt];
    assign dbg_data = rf[dbg_addr];
    assign instr_done = state == WB;
    assign halted = state == HALTED;
    assign wr_en = op <= 4'd5;
    assign wr_sel = op <= 4'd3 ? rd : rt;
    assign pc_n = pc + PC_W'(1) + (taken ? PC_W'($signed(ir[7:0])) : '0);

    always_comb begin
        b_op = op == 4'd4 ? imm_x : b;
        sum = a + b_op;
        diff = a - b;
        ovf_add = (a[DATA_W-1] == b_op[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        ovf_sub = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
        res = (op == 4'd0 || op == 4'd4) ? sum :
              (op == 4'd1 || op == 4'd6) ? diff :
              op == 4'd2 ? (a & b) :
              op == 4'd3 ? (a | b) : imm_x;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (run || step) ? FETCH : IDLE;
            FETCH:   state_n = DECODE;
            DECODE:  state_n = EXEC;
            EXEC:    state_n = op == 4'hF ? HALTED : WB;
            WB:      state_n = run ? FETCH : IDLE;
            default: state_n = HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_general) begin
            state <= IDLE;
            pc <= '0;
            imem_addr <= '0;
            ir <= '0;
            rf <= '{default: '0};
            alu_result <= '0;
            ovf <= 1'b0;
            taken <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DECODE)
                ir <= imem_data;
            if (state == EXEC) begin
                if (op <= 4'd6)
                    alu_result <= res;
                if (op == 4'd0 || op == 4'd1 || op == 4'd4)
                    ovf <= op == 4'd1 ? ovf_sub : ovf_add;
                else if (op == 4'd2 || op == 4'd3 || op == 4'd5)
                    ovf <= 1'b0;
                taken <= op == 4'd6 && a == b;
            end
            if (state == WB) begin
                if (wr_en && wr_sel != 2'd0)
                    rf[wr_sel] <= alu_result;
                // imem_addr tracks pc so the ROM has already produced the word by DECODE
                pc <= pc_n;
                imem_addr <= pc_n;
            end
        end
    end
endmodule

// File: tb/tb_pdatapath_mc.sv
// tb_pdatapath_mc: directed self-checking bench for pdatapath_mc with a synchronous ROM model
module tb_pdatapath_mc;
    logic clk = 1'b0;
    logic rst_general, run, step;
    logic [7:0] imem_addr, pc, dbg_data, alu_result;
    logic [15:0] imem_data;
    logic [1:0] dbg_addr;
    logic ovf, halted, instr_done;
    logic [15:0] rom [256];
    int checks = 0;
    int passes = 0;

    // expected results per executed instruction: alu (-1 = not checked), ovf, pc after, reg, reg value
    int t_alu [12] = '{'h7F, 'h80, 'h01, 'h7F, 'hFF, 'h05, 'hFF, 'h00, -1, 'hFF, 'h00, 'h00};
    int t_ovf [12] = '{0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    int t_pc  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 13, 11};
    int t_r   [12] = '{1, 2, 1, 3, 3, 0, 1, 2, 2, 1, 1, 0};
    int t_rv  [12] = '{'h7F, 'h80, 'h01, 'h7F, 'hFF, 'h00, 'hFF, 'h00, 'h00, 'hFF, 'hFF, 'h00};

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= rom[imem_addr];

    pdatapath_mc dut (
        .clk(clk), .rst_general(rst_general), .run(run), .step(step),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .pc(pc), .alu_result(alu_result), .ovf(ovf),
        .halted(halted), .instr_done(instr_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk_reg(input logic [1:0] r, input logic [31:0] v);
        dbg_addr = r;
        #1;
        chk($sformatf("R%0d", r), dbg_data, v);
    endtask

    task automatic do_reset;
        rst_general = 1'b1;
        run = 1'b0;
        step = 1'b0;
        tick;
        rst_general = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick;
            n++;
        end while (!instr_done && n < 40);
        chk("done_seen", instr_done, 1);
    endtask

    task automatic wait_halt;
        int n = 0;
        int d = 0;
        while (!halted && n < 20) begin
            tick;
            n++;
            d += int'(instr_done);
        end
        chk("halt_seen", halted, 1);
        chk("halt_no_done", d, 0);
    endtask

    initial begin
        int n, d;
        for (int i = 0; i < 256; i++) rom[i] = 16'h7000;
        rom[0]  = 16'h517F;
        rom[1]  = 16'h4601;
        rom[2]  = 16'h5101;
        rom[3]  = 16'h19C0;
        rom[4]  = 16'h11C0;
        rom[5]  = 16'h5005;
        rom[6]  = 16'h3740;
        rom[7]  = 16'h0A80;
        rom[8]  = 16'h7000;
        rom[9]  = 16'h6610;
        rom[10] = 16'h6502;
        rom[11] = 16'hF000;
        rom[12] = 16'h7000;
        rom[13] = 16'h60FD;
        dbg_addr = 2'd0;
        do_reset;
        chk("rst_pc", pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_alu", alu_result, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_halted", halted, 0);
        chk("rst_done", instr_done, 0);
        for (int r = 0; r < 4; r++) chk_reg(2'(r), 0);

        run = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wait_done(n);
            chk($sformatf("gap%0d", k), k == 0 ? n : n + 1, 4);
            if (t_alu[k] >= 0) chk($sformatf("alu%0d", k), alu_result, t_alu[k]);
            chk($sformatf("ovf%0d", k), ovf, t_ovf[k]);
            tick;
            chk($sformatf("pc%0d", k), pc, t_pc[k]);
            chk_reg(2'(t_r[k]), t_rv[k]);
        end
        wait_halt;
        chk("halt_pc", pc, 11);
        chk("halt_alu", alu_result, 0);
        d = 0;
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            tick;
            d += int'(instr_done);
        end
        run = 1'b0;
        step = 1'b0;
        chk("halt_toggle_done", d, 0);
        chk("halt_toggle_pc", pc, 11);
        chk("halt_toggle_halted", halted, 1);
        do_reset;
        chk("unhalt_halted", halted, 0);
        chk("unhalt_pc", pc, 0);

        run = 1'b1;
        wait_done(n);
        tick;
        tick;
        tick;
        chk_reg(2'd1, 'h7F);
        rst_general = 1'b1;
        run = 1'b0;
        tick;
        rst_general = 1'b0;
        chk("mid_pc", pc, 0);
        chk("mid_alu", alu_result, 0);
        chk("mid_ovf", ovf, 0);
        chk("mid_halted", halted, 0);
        chk("mid_done", instr_done, 0);
        for (int r = 0; r < 4; r++) chk_reg(2'(r), 0);
        d = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            d += int'(instr_done);
        end
        chk("idle_done", d, 0);
        chk("idle_pc", pc, 0);

        step = 1'b1;
        tick;
        chk("step_fetch_done", instr_done, 0);
        tick;
        step = 1'b0;
        tick;
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("step_lat_done", instr_done, 1);
        chk("step_alu", alu_result, 'h7F);
        tick;
        chk("step_pc", pc, 1);
        chk_reg(2'd1, 'h7F);
        d = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            d += int'(instr_done);
        end
        chk("step_idle_done", d, 0);
        chk("step_idle_pc", pc, 1);
        step = 1'b1;
        tick;
        step = 1'b0;
        wait_done(n);
        chk("step2_lat", n + 1, 4);
        chk("step2_ovf", ovf, 1);
        tick;
        chk("step2_pc", pc, 2);
        chk_reg(2'd2, 'h80);

        do_reset;
        rom[0] = 16'h60FE;
        rom[1] = 16'hF000;
        rom[255] = 16'h6001;
        run = 1'b1;
        wait_done(n);
        tick;
        chk("wrap_back_pc", pc, 'hFF);
        wait_done(n);
        tick;
        chk("wrap_fwd_pc", pc, 'h01);
        wait_halt;
        chk("wrap_halt_pc", pc, 'h01);
        run = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pdatapath_mc.md
Name: pdatapath_mc

Overview:
Parametrised multi-cycle successor to the single-cycle 8-bit processor datapath. It contains the instruction decoder, a 4-entry register file, the ALU, a PC and a control FSM. Each instruction runs FETCH→DECODE→EXEC→WB from a synchronous external instruction ROM. It adds run and single-step modes, taken/not-taken branches, a HALT instruction, a sticky-free overflow flag and a debug register read port. It sits under the board top-level, driven by the board clock, with step fed by the debounced PBN1 pulse.

Parameters:
DATA_W, 8, datapath/register width; legal range 8..32.
PC_W, 8, program counter / instruction address width.

Ports:
clk  in  1  system clock
rst_general  in  1  synchronous, active-high reset
run  in  1  1 = free-run mode; 0 = single-step mode
step  in  1  one-cycle pulse; starts one instruction when in IDLE
imem_addr  out  PC_W  instruction ROM address (registered)
imem_data  in  16  ROM data, valid the cycle after imem_addr is presented
dbg_addr  in  2  debug register select
dbg_data  out  DATA_W  combinational read of register dbg_addr
pc  out  PC_W  current PC
alu_result  out  DATA_W  result of the last executed instruction
ovf  out  1  signed overflow of the last ADD/SUB/ADDI
halted  out  1  high in HALTED state
instr_done  out  1  one-cycle pulse during WB

Behaviour:
- Reset: one clock, synchronous, active-high. Every rst_general=1 edge forces the following, including mid-instruction: state=IDLE, pc=0, imem_addr=0, IR=0, R0..R3=0, alu_result=0, ovf=0, halted=0, instr_done=0.
- Encoding: opcode[15:12], rs[11:10], rt[9:8], rd[7:6], imm[7:0].
- imm is sign-extended to DATA_W.
- Opcodes:
  - 0 ADD: rd=rs+rt
  - 1 SUB: rd=rs-rt
  - 2 AND: rd=rs&rt
  - 3 OR: rd=rs|rt
  - 4 ADDI: rt=rs+imm
  - 5 LI: rt=imm
  - 6 BEQ: if rs==rt then pc=pc+1+imm, else pc+1
  - F HALT
  - Others: NOP (pc+1, no write).
- R0 always reads 0. Writes to R0 are discarded, but alu_result still updates.
- Arithmetic: modulo 2^DATA_W.
  - ovf = signed overflow (two's complement) for ADD/SUB/ADDI.
  - ovf = 0 for AND/OR/LI.
  - ovf is unchanged for BEQ/NOP/HALT.
- PC arithmetic: modulo 2^PC_W; pc+1 and branch targets wrap.
- FSM states and transitions:
  - IDLE: if run=1, or step=1 → FETCH; else stay.
  - FETCH: drive imem_addr=pc → DECODE.
  - DECODE: IR<=imem_data → EXEC.
  - EXEC: compute; latch alu_result/ovf/branch decision. For BEQ, alu_result=rs-rt. If opcode=F → HALTED, else → WB.
  - WB: register write, pc update, instr_done=1. Then → FETCH if run=1, else → IDLE.
  - HALTED: halted=1; pc holds the HALT address; step/run ignored; exits only on reset.
- Latency: 4 cycles per instruction in run mode. In step mode, 4 cycles from the step-accepted edge to instr_done.
- step is sampled only in IDLE; pulses in other states are ignored (no queuing). run may change at any time and is sampled only in IDLE and WB.
- Register file: written at the WB→next edge. Reads are combinational in EXEC, so back-to-back dependencies need no forwarding.
- dbg_data reflects a write on the clock after WB.

Test Plan:
- Reset mid-EXEC (run=1, program running) → next cycle: pc=0, alu_result=0, ovf=0, halted=0, all dbg reads 0, state IDLE.
- Run: LI R1,0x7F; ADDI R2,R1,1 (DATA_W=8) → after 2nd instr_done: R2=0x80, ovf=1, alu_result=0x80, pc=2. instr_done pulses are exactly 4 cycles apart.
- LI R0,0x05; SUB R3,R0,R1 with R1=0x01 → R0 reads 0x00; R3=0xFF; ovf=0.
- BEQ R1,R1,0xFE at pc=3 → pc=2 (taken, backward). BEQ R1,R2 with R1≠R2 at pc=3 → pc=4. PC_W=8 wrap: BEQ taken at pc=0xFF with imm=0x01 → pc=0x01.
- Step mode (run=0): one step pulse → exactly one instr_done 4 cycles later, then IDLE. Extra step pulses during FETCH/EXEC are ignored (pc advances by 1 only).
- HALT at pc=5 → halted=1, pc=5, no instr_done. step/run toggled for 20 cycles → no change. Reset → halted=0, pc=0.
